// File: rtl/hfifo_pkg.sv
// hfifo_pkg: shared types and helpers for the clocked handshake FIFO.
//
// Contents:
//   in_state_t   - upstream (write side) handshake FSM states
//   out_state_t  - downstream (read side) handshake FSM states
//   ptr_next()   - pointer increment with explicit wrap at an arbitrary depth
package hfifo_pkg;

    // Upstream side: IN_IDLE waits for a request, IN_ACK holds the
    // acknowledge until the request returns to zero.
    typedef enum logic [0:0] {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_t;

    // Downstream side: OUT_REQ presents data, OUT_WAIT waits for the
    // acknowledge to return to zero before the next entry may be offered.
    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_t;

    // Next pointer value. DEPTH need not be a power of two, so the wrap
    // from depth-1 back to 0 is explicit rather than relying on overflow.
    function automatic int unsigned ptr_next(input int unsigned ptr,
                                             input int unsigned depth);
        int unsigned nxt;
        if (ptr >= (depth - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage : hfifo_pkg

// File: rtl/hfifo_sync.sv
// sync2: two-flop synchroniser for a single control bit coming from an
// asynchronous neighbour. Only used when HFIFO_SYNC_EN is defined.
//
// Ports:
//   clk - clock, rising edge
//   rst - synchronous reset, active-low; both flops clear to 0
//   d   - asynchronous input bit
//   q   - synchronised output bit (two clocks of latency)
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; the first stage may go metastable, the second
    // gives it a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule : sync2

// File: rtl/hfifo.sv
// hfifo: multi-entry FIFO with 4-phase return-to-zero request/acknowledge
// handshakes on both sides. Provides elasticity deeper than one place
// between synchronous handshake stages and reports its occupancy.
//
// Parameters:
//   N        - data width in bits (>= 1)
//   DEPTH    - number of storage entries (>= 1, any value)
//   RdataVal - reset value of d_o
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-low
//   r_i   in   upstream request
//   a_i   out  upstream acknowledge
//   d_i   in   upstream data, valid while r_i=1
//   r_o   out  downstream request
//   a_o   in   downstream acknowledge
//   d_o   out  downstream data, stable while r_o=1
//   level out  number of stored entries
//
// Optional feature (macro HFIFO_SYNC_EN):
//   When defined, r_i and a_o pass through two-flop synchronisers before
//   reaching the FSMs, so asynchronous neighbours may be attached. Every
//   handshake response is then two cycles later. d_i is sampled on the
//   edge at which the synchronised r_i is acted upon, so the upstream
//   side must keep d_i stable for the whole request phase.
//   When undefined, r_i and a_o must be synchronous to clk.
module hfifo
    import hfifo_pkg::*;
#(
    parameter int             N        = 1,
    parameter int             DEPTH    = 4,
    parameter logic [N-1:0]   RdataVal = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       r_i,
    output logic                       a_i,
    input  logic [N-1:0]               d_i,
    output logic                       r_o,
    input  logic                       a_o,
    output logic [N-1:0]               d_o,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    // Control inputs as seen by the FSMs.
    logic r_in_s;
    logic a_out_s;

`ifdef HFIFO_SYNC_EN
    sync2 u_sync_r_i (
        .clk (clk),
        .rst (rst),
        .d   (r_i),
        .q   (r_in_s)
    );

    sync2 u_sync_a_o (
        .clk (clk),
        .rst (rst),
        .d   (a_o),
        .q   (a_out_s)
    );
`else
    assign r_in_s  = r_i;
    assign a_out_s = a_o;
`endif

    // Storage and bookkeeping registers.
    logic [N-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [N-1:0]  d_o_r;
    logic          a_i_r;
    logic          r_o_r;
    in_state_t     in_state_r;
    out_state_t    out_state_r;

    // Next-state values from the combinational FSM processes.
    in_state_t     in_state_s;
    out_state_t    out_state_s;
    logic          a_i_s;
    logic          r_o_s;
    logic          wr_en_s;
    logic          ld_en_s;
    logic          pop_s;
    logic [LW-1:0] level_s;

    // Upstream FSM. Fullness comes from the registered level, so a slot
    // freed by a pop only becomes writable one edge later (no bypass).
    always_comb begin
        in_state_s = in_state_r;
        a_i_s      = a_i_r;
        wr_en_s    = 1'b0;
        case (in_state_r)
            IN_IDLE: begin
                if (r_in_s && (level_r < LVL_FULL)) begin
                    wr_en_s    = 1'b1;
                    a_i_s      = 1'b1;
                    in_state_s = IN_ACK;
                end else begin
                    a_i_s      = 1'b0;
                end
            end
            IN_ACK: begin
                if (!r_in_s) begin
                    a_i_s      = 1'b0;
                    in_state_s = IN_IDLE;
                end else begin
                    a_i_s      = 1'b1;
                end
            end
            default: begin
                a_i_s      = 1'b0;
                in_state_s = IN_IDLE;
            end
        endcase
    end

    // Downstream FSM. Emptiness comes from the registered level, so an
    // entry written on one edge is loaded no earlier than the next edge.
    // An acknowledge seen in OUT_IDLE blocks the load and is otherwise
    // ignored.
    always_comb begin
        out_state_s = out_state_r;
        r_o_s       = r_o_r;
        ld_en_s     = 1'b0;
        pop_s       = 1'b0;
        case (out_state_r)
            OUT_IDLE: begin
                if ((level_r != {LW{1'b0}}) && !a_out_s) begin
                    ld_en_s     = 1'b1;
                    r_o_s       = 1'b1;
                    out_state_s = OUT_REQ;
                end else begin
                    r_o_s       = 1'b0;
                end
            end
            OUT_REQ: begin
                if (a_out_s) begin
                    pop_s       = 1'b1;
                    r_o_s       = 1'b0;
                    out_state_s = OUT_WAIT;
                end else begin
                    r_o_s       = 1'b1;
                end
            end
            OUT_WAIT: begin
                r_o_s = 1'b0;
                if (!a_out_s) begin
                    out_state_s = OUT_IDLE;
                end else begin
                    out_state_s = OUT_WAIT;
                end
            end
            default: begin
                r_o_s       = 1'b0;
                out_state_s = OUT_IDLE;
            end
        endcase
    end

    // Occupancy update; a write and a pop on the same edge cancel out.
    always_comb begin
        level_s = level_r;
        case ({wr_en_s, pop_s})
            2'b10:   level_s = level_r + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_s = level_r - {{(LW-1){1'b0}}, 1'b1};
            default: level_s = level_r;
        endcase
    end

    // Control and output registers; reset abandons any handshake in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_state_r  <= IN_IDLE;
            out_state_r <= OUT_IDLE;
            a_i_r       <= 1'b0;
            r_o_r       <= 1'b0;
            d_o_r       <= RdataVal;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            level_r     <= {LW{1'b0}};
        end else begin
            in_state_r  <= in_state_s;
            out_state_r <= out_state_s;
            a_i_r       <= a_i_s;
            r_o_r       <= r_o_s;
            level_r     <= level_s;
            if (ld_en_s) begin
                d_o_r <= mem_r[rd_ptr_r];
            end
            if (wr_en_s) begin
                wr_ptr_r <= PW'(ptr_next(32'(wr_ptr_r), DEPTH));
            end
            if (pop_s) begin
                rd_ptr_r <= PW'(ptr_next(32'(rd_ptr_r), DEPTH));
            end
        end
    end

    // Entry storage; contents are only meaningful below level, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= d_i;
        end
    end

    assign a_i   = a_i_r;
    assign r_o   = r_o_r;
    assign d_o   = d_o_r;
    assign level = level_r;

endmodule : hfifo

// File: tb/tb_hfifo.sv
// tb_hfifo: self-checking bench for hfifo.
// DUT A (N=8, DEPTH=4, RdataVal=8'h3C) is driven from a per-cycle vector
// table covering reset, latency, backpressure, mid-operation reset,
// ignored acknowledges and a same-edge write/pop. DUT B (N=8, DEPTH=3)
// streams 20 random values through randomly delayed handshakes and is
// compared against the sent sequence and a bench-side occupancy model.
module tb_hfifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A
    logic       rst_a, r_i_a, a_i_a, r_o_a, a_o_a;
    logic [7:0] d_i_a, d_o_a;
    logic [2:0] level_a;

    // DUT B
    logic       rst_b, r_i_b, a_i_b, r_o_b, a_o_b;
    logic [7:0] d_i_b, d_o_b;
    logic [1:0] level_b;

    hfifo #(.N(8), .DEPTH(4), .RdataVal(8'h3C)) u_dut_a (
        .clk(clk), .rst(rst_a), .r_i(r_i_a), .a_i(a_i_a), .d_i(d_i_a),
        .r_o(r_o_a), .a_o(a_o_a), .d_o(d_o_a), .level(level_a)
    );

    hfifo #(.N(8), .DEPTH(3), .RdataVal(8'h00)) u_dut_b (
        .clk(clk), .rst(rst_b), .r_i(r_i_b), .a_i(a_i_b), .d_i(d_i_b),
        .r_o(r_o_b), .a_o(a_o_b), .d_o(d_o_b), .level(level_b)
    );

    typedef struct {
        logic       rst;
        logic       r_i;
        logic [7:0] d_i;
        logic       a_o;
        logic       e_ai;
        logic       e_ro;
        logic [7:0] e_do;
        logic [2:0] e_lvl;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];

    localparam int NS = 20;
    logic [7:0] vals [NS];
    bit         stream_done;
    int         model_lvl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b0; r_i_a = 1'b0; d_i_a = 8'h00; a_o_a = 1'b0;
        rst_b = 1'b0; r_i_b = 1'b0; d_i_b = 8'h00; a_o_b = 1'b0;

`ifndef HFIFO_SYNC_EN
        //         rst   r_i   d_i    a_o     a_i   r_o   d_o    lvl
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 1'b1,  1'b0, 1'b0, 8'h3C, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b1,  1'b0, 1'b0, 8'h3C, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0,  1'b1, 1'b0, 8'h3C, 3'd1};
        vecs[3]  = '{1'b1, 1'b1, 8'hA5, 1'b0,  1'b1, 1'b1, 8'hA5, 3'd1};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'hA5, 3'd0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'hA5, 3'd0};
        vecs[6]  = '{1'b1, 1'b1, 8'h01, 1'b0,  1'b1, 1'b0, 8'hA5, 3'd1};
        vecs[7]  = '{1'b1, 1'b0, 8'h01, 1'b0,  1'b0, 1'b1, 8'h01, 3'd1};
        vecs[8]  = '{1'b1, 1'b1, 8'h02, 1'b0,  1'b1, 1'b1, 8'h01, 3'd2};
        vecs[9]  = '{1'b1, 1'b0, 8'h02, 1'b0,  1'b0, 1'b1, 8'h01, 3'd2};
        vecs[10] = '{1'b1, 1'b1, 8'h03, 1'b0,  1'b1, 1'b1, 8'h01, 3'd3};
        vecs[11] = '{1'b1, 1'b0, 8'h03, 1'b0,  1'b0, 1'b1, 8'h01, 3'd3};
        vecs[12] = '{1'b1, 1'b1, 8'h04, 1'b0,  1'b1, 1'b1, 8'h01, 3'd4};
        vecs[13] = '{1'b1, 1'b0, 8'h04, 1'b0,  1'b0, 1'b1, 8'h01, 3'd4};
        vecs[14] = '{1'b1, 1'b1, 8'h05, 1'b0,  1'b0, 1'b1, 8'h01, 3'd4};
        vecs[15] = '{1'b1, 1'b1, 8'h05, 1'b0,  1'b0, 1'b1, 8'h01, 3'd4};
        vecs[16] = '{1'b1, 1'b1, 8'h05, 1'b1,  1'b0, 1'b0, 8'h01, 3'd3};
        vecs[17] = '{1'b1, 1'b1, 8'h05, 1'b1,  1'b1, 1'b0, 8'h01, 3'd4};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h01, 3'd4};
        vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b1, 8'h02, 3'd4};
        vecs[20] = '{1'b1, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'h02, 3'd3};
        vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h02, 3'd3};
        vecs[22] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b1, 8'h03, 3'd3};
        vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'h03, 3'd2};
        vecs[24] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h03, 3'd2};
        vecs[25] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b1, 8'h04, 3'd2};
        vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h3C, 3'd0};
        vecs[27] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h3C, 3'd0};
        vecs[28] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h3C, 3'd0};
        vecs[29] = '{1'b1, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'h3C, 3'd0};
        vecs[30] = '{1'b1, 1'b1, 8'h77, 1'b1,  1'b1, 1'b0, 8'h3C, 3'd1};
        vecs[31] = '{1'b1, 1'b0, 8'h77, 1'b1,  1'b0, 1'b0, 8'h3C, 3'd1};
        vecs[32] = '{1'b1, 1'b0, 8'h77, 1'b0,  1'b0, 1'b1, 8'h77, 3'd1};
        vecs[33] = '{1'b1, 1'b1, 8'h88, 1'b1,  1'b1, 1'b0, 8'h77, 3'd1};
        vecs[34] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h77, 3'd1};
        vecs[35] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b1, 8'h88, 3'd1};
        vecs[36] = '{1'b1, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'h88, 3'd0};
        vecs[37] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h88, 3'd0};

        for (int i = 0; i < NV; i++) begin
            rst_a = vecs[i].rst;
            r_i_a = vecs[i].r_i;
            d_i_a = vecs[i].d_i;
            a_o_a = vecs[i].a_o;
            step();
            check($sformatf("vec%0d_a_i", i),   32'(a_i_a),   32'(vecs[i].e_ai));
            check($sformatf("vec%0d_r_o", i),   32'(r_o_a),   32'(vecs[i].e_ro));
            check($sformatf("vec%0d_d_o", i),   32'(d_o_a),   32'(vecs[i].e_do));
            check($sformatf("vec%0d_level", i), 32'(level_a), 32'(vecs[i].e_lvl));
        end
`else
        // Synchronised control inputs: every response is two edges later.
        rst_a = 1'b0; r_i_a = 1'b1; a_o_a = 1'b1;
        step(); step();
        check("sync_rst_a_i",   32'(a_i_a),   32'h0);
        check("sync_rst_r_o",   32'(r_o_a),   32'h0);
        check("sync_rst_d_o",   32'(d_o_a),   32'h3C);
        check("sync_rst_level", 32'(level_a), 32'h0);
        rst_a = 1'b1; r_i_a = 1'b1; d_i_a = 8'hA5; a_o_a = 1'b0;
        step();
        check("sync_e0_a_i", 32'(a_i_a), 32'h0);
        step();
        check("sync_e1_a_i", 32'(a_i_a), 32'h0);
        step();
        check("sync_e2_a_i",   32'(a_i_a),   32'h1);
        check("sync_e2_r_o",   32'(r_o_a),   32'h0);
        check("sync_e2_level", 32'(level_a), 32'h1);
        step();
        check("sync_e3_r_o", 32'(r_o_a), 32'h1);
        check("sync_e3_d_o", 32'(d_o_a), 32'hA5);
        r_i_a = 1'b0; a_o_a = 1'b1;
        step(); step();
        check("sync_ack_hold_r_o", 32'(r_o_a), 32'h1);
        step();
        check("sync_pop_r_o",   32'(r_o_a),   32'h0);
        check("sync_pop_level", 32'(level_a), 32'h0);
        check("sync_pop_a_i",   32'(a_i_a),   32'h0);
        a_o_a = 1'b0;
        step();
`endif

        // Streaming through DEPTH=3 with random downstream delays.
        for (int i = 0; i < NS; i++) begin
            vals[i] = 8'($urandom_range(0, 255));
        end
        step();
        rst_b = 1'b1;
        stream_done = 1'b0;
        model_lvl = 0;
        fork
            begin : upstream
                for (int i = 0; i < NS; i++) begin
                    int n;
                    d_i_b = vals[i];
                    r_i_b = 1'b1;
                    n = 0;
                    while (a_i_b !== 1'b1 && n < 200) begin
                        step();
                        n++;
                    end
                    if (a_i_b !== 1'b1) begin
                        check($sformatf("stream_ack_rise%0d", i), 32'(a_i_b), 32'h1);
                        break;
                    end
                    r_i_b = 1'b0;
                    n = 0;
                    while (a_i_b !== 1'b0 && n < 200) begin
                        step();
                        n++;
                    end
                    if (a_i_b !== 1'b0) begin
                        check($sformatf("stream_ack_fall%0d", i), 32'(a_i_b), 32'h0);
                        break;
                    end
                end
            end
            begin : downstream
                for (int i = 0; i < NS; i++) begin
                    int n;
                    int dly;
                    n = 0;
                    while (r_o_b !== 1'b1 && n < 200) begin
                        step();
                        n++;
                    end
                    if (r_o_b !== 1'b1) begin
                        check($sformatf("stream_req%0d", i), 32'(r_o_b), 32'h1);
                        break;
                    end
                    check($sformatf("stream_data%0d", i), 32'(d_o_b), 32'(vals[i]));
                    dly = $urandom_range(0, 5);
                    for (int k = 0; k < dly; k++) begin
                        step();
                    end
                    a_o_b = 1'b1;
                    n = 0;
                    while (r_o_b !== 1'b0 && n < 200) begin
                        step();
                        n++;
                    end
                    a_o_b = 1'b0;
                    if (r_o_b !== 1'b0) begin
                        check($sformatf("stream_req_fall%0d", i), 32'(r_o_b), 32'h0);
                        break;
                    end
                end
                step(); step(); step();
                stream_done = 1'b1;
            end
            begin : occupancy
                logic ai_prev;
                logic ro_prev;
                ai_prev = 1'b0;
                ro_prev = 1'b0;
                while (!stream_done) begin
                    @(negedge clk);
                    if (a_i_b && !ai_prev) model_lvl++;
                    if (!r_o_b && ro_prev) model_lvl--;
                    ai_prev = a_i_b;
                    ro_prev = r_o_b;
                    check("stream_level", 32'(level_b), 32'(model_lvl));
                    if (model_lvl > 3) begin
                        check("stream_level_bound", 32'(model_lvl), 32'd3);
                    end
                end
            end
        join
        check("stream_final_level", 32'(level_b), 32'h0);
        check("stream_final_r_o",   32'(r_o_b),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hfifo

// File: doc/hfifo.md
Name: hfifo

Overview:
- Clocked, parametrised successor to the single-place handshake latch.
- Multi-entry FIFO with the same 4-phase return-to-zero request/acknowledge protocol on both sides: r_i/a_i/d_i in, r_o/a_o/d_o out.
- Placed between handshake stages that need elasticity deeper than one place, in the synchronous parts of the design.
- Adds an occupancy output and optional input synchronisers for asynchronous neighbours.

Parameters:
- N, 1, data width in bits (>=1).
- DEPTH, 4, number of storage entries (>=1; need not be a power of 2).
- RdataVal, 0, reset value of d_o (N bits).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low (rst=0 at a rising edge resets).
- r_i  input  1  upstream request.
- a_i  output  1  upstream acknowledge.
- d_i  input  N  upstream data; valid while r_i=1.
- r_o  output  1  downstream request.
- a_o  input  1  downstream acknowledge.
- d_o  output  N  downstream data; stable while r_o=1.
- level  output  $clog2(DEPTH+1)  current entry count.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at an edge):
  - a_i=0, r_o=0, d_o=RdataVal, level=0.
  - Read and write pointers = 0; both FSMs go to IDLE.
  - Any handshake in progress is abandoned; the entry is not stored or not popped. Neighbours must restart from r=0.
- Input FSM:
  - IN_IDLE (a_i=0): if r_i=1 and level<DEPTH, then at the edge write mem[wr_ptr]=d_i, increment wr_ptr, set a_i=1, go to IN_ACK. If full, stay in IN_IDLE with a_i=0 (backpressure).
  - IN_ACK (a_i=1): if r_i=0, set a_i=0 and go to IN_IDLE. Otherwise hold.
- Output FSM:
  - OUT_IDLE (r_o=0): if level>0 and a_o=0, load d_o=mem[rd_ptr], set r_o=1, go to OUT_REQ.
  - OUT_REQ (r_o=1, d_o held): if a_o=1, pop (increment rd_ptr), set r_o=0, go to OUT_WAIT.
  - OUT_WAIT (r_o=0): if a_o=0, go to OUT_IDLE.
  - d_o keeps its last value after the pop until the next load.
- Pointers wrap explicitly from DEPTH-1 to 0.
- level = writes minus pops. On a same-edge write and pop, level is unchanged.
- The full check uses the registered level. A slot freed by a pop on edge k is writable at edge k+1 (no bypass).
- The empty check uses the registered level. An entry written on edge k can be loaded to d_o at edge k+1 at the earliest.
- Latency (macro off, empty FIFO):
  - r_i rise sampled at edge k gives a_i=1 after edge k.
  - r_o=1 with valid d_o after edge k+1.
- Throughput: at most one transfer per 2 cycles per side.
- Protocol violations are ignored and do not corrupt state: a_o=1 while in OUT_IDLE, r_i toggling within one cycle.
- DEPTH=1 behaves as a clocked single-place latch.

Optional Feature:
- Macro HFIFO_SYNC_EN.
- Defined: r_i and a_o each pass through a 2-flop synchroniser before the FSMs. Every handshake response is 2 cycles later: r_i to a_i is 3 edges, r_i to r_o on an empty FIFO is 4 edges. d_i is sampled on the same edge the synchronised r_i is seen, so upstream holds data stable for the whole request phase.
- Undefined: r_i and a_o are used directly. Both must be synchronous to clk.

Decomposition:
- Package hfifo_pkg holds:
  - typedef enum in_state_t {IN_IDLE, IN_ACK};
  - typedef enum out_state_t {OUT_IDLE, OUT_REQ, OUT_WAIT};
  - a function computing the pointer-wrap increment for a given DEPTH.
- One sub-module: sync2, a 2-flop synchroniser with clk, active-low synchronous rst, and reset value 0. It is instantiated only under HFIFO_SYNC_EN.

Test Plan:
- Reset: drive rst=0 for 2 edges with r_i=1, a_o=1, RdataVal=8'h3C -> a_i=0, r_o=0, d_o=8'h3C, level=0. After release with r_i=1, a_i=1 follows one edge later.
- Latency (N=8, DEPTH=4, macro off): raise r_i with d_i=8'hA5 at edge 0 -> a_i=1 after edge 0, r_o=1 with d_o=8'hA5 after edge 1, level=1. Raise a_o -> r_o=0 and level=0 one edge later.
- Full/backpressure: hold a_o=0 and push 8'h01..8'h04 -> level=4. A fifth request with 8'h05 leaves a_i=0. Complete one downstream handshake (d_o=8'h01) -> 8'h05 is accepted the edge after the pop and level returns to 4.
- Wrap/order (DEPTH=3): stream 20 random values with random a_o delays of 0-5 cycles -> output sequence equals input sequence, pointers wrap 2 to 0, level never exceeds 3.
- Mid-operation reset: pulse rst=0 while in OUT_REQ with level=2 -> r_o=0, d_o=RdataVal, level=0. After release with a_o=0 and no new input, r_o stays 0.
- Macro on: with HFIFO_SYNC_EN defined, repeat the latency test -> a_i=1 after edge 2, r_o=1 after edge 3, data still 8'hA5.
